// File: rtl/vec_pkg.sv
// Shared RVV encoding constants and types for the vector issue front end and lane controller.
package vec_pkg;

    localparam logic [6:0] OPC_OPV   = 7'b1010111;
    localparam logic [6:0] OPC_LOAD  = 7'b0000111;
    localparam logic [6:0] OPC_STORE = 7'b0100111;

    localparam logic [2:0] F3_OPIVV = 3'b000;
    localparam logic [2:0] F3_OPMVV = 3'b010;
    localparam logic [2:0] F3_OPCFG = 3'b111;

    localparam logic [5:0] F6_VADD = 6'b000000;
    localparam logic [5:0] F6_VSUB = 6'b000010;
    localparam logic [5:0] F6_VAND = 6'b001001;
    localparam logic [5:0] F6_VOR  = 6'b001010;
    localparam logic [5:0] F6_VXOR = 6'b001011;
    localparam logic [5:0] F6_VMUL = 6'b100101;

    localparam int unsigned VT_VSEW_LSB = 3;
    localparam int unsigned VT_VTA      = 6;
    localparam int unsigned VT_VMA      = 7;
    localparam int unsigned VT_VILL     = 15;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_XOR = 3'd4,
        ALU_MUL = 3'd5
    } alu_op_e;

    typedef enum logic [1:0] {
        CLS_ILLEGAL,
        CLS_ALU,
        CLS_LS,
        CLS_CFG
    } instr_class_e;

    // Vector load/store width encodings (8/16/32/64-bit elements).
    function automatic logic is_vec_width(input logic [2:0] width);
        return (width == 3'b000) || (width == 3'b101) || (width == 3'b110) || (width == 3'b111);
    endfunction

endpackage

// File: rtl/vector_instr_decoder_vl_calc.sv
// vsetvli arithmetic: derives vtype and vl from zimm and the requested AVL.
module vl_calc
    import vec_pkg::*;
#(
    parameter int unsigned VLEN = 256,
    parameter int unsigned VL_W = 9
) (
    input  logic [10:0]     zimm,
    input  logic [31:0]     avl,
    input  logic            rs1_zero,
    output logic [15:0]     vtype,
    output logic [VL_W-1:0] vl,
    output logic            vill
);

    logic [2:0]  vlmul;
    logic [2:0]  vsew;
    logic [31:0] vlmax;
    logic [31:0] avl_eff;
    logic [31:0] vl_full;
    logic        unused_bits;

    assign vlmul = zimm[2:0];
    assign vsew  = zimm[5:3];

    always_comb begin
        vtype   = '0;
        vl      = '0;
        vill    = vlmul[2] | vsew[2];
        vlmax   = (32'(VLEN) >> (32'd3 + 32'(vsew))) << vlmul;
        avl_eff = rs1_zero ? vlmax : avl;
        // full 32-bit compare so a large AVL cannot wrap below VLMAX
        vl_full = (avl_eff < vlmax) ? avl_eff : vlmax;
        if (vill) begin
            vtype[VT_VILL] = 1'b1;
        end else begin
            vtype[2:0]                       = vlmul;
            vtype[VT_VSEW_LSB +: 3]          = vsew;
            vtype[VT_VTA]                    = zimm[6];
            vtype[VT_VMA]                    = zimm[7];
            vl                               = vl_full[VL_W-1:0];
        end
    end

    assign unused_bits = ^{zimm[10:8], vl_full[31:VL_W]};

endmodule

// File: rtl/vector_instr_decoder.sv
// RVV issue front end: handshakes instructions, decodes them for the lane controller, owns vtype/vl.
module vector_instr_decoder
    import vec_pkg::*;
#(
    parameter int unsigned VLEN    = 256,
    parameter int unsigned TIMEOUT = 1023,
    parameter int unsigned VL_W    = $clog2(VLEN) + 1
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            instr_valid,
    output logic            instr_ready,
    input  logic [31:0]     instr,
    input  logic [31:0]     avl_i,
    input  logic            ctrl_done,
    output logic [2:0]      ALU_op,
    output logic [4:0]      address_s1,
    output logic [4:0]      address_s2,
    output logic [4:0]      address_dest,
    output logic            is_alu_op,
    output logic            is_load_store_op,
    output logic            is_vlen_op,
    output logic [15:0]     vtype_o,
    output logic [VL_W-1:0] vl_o,
    output logic            instr_retired,
    output logic            illegal_instr,
    output logic            timeout_err
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, BUSY, CFG} state_e;

    state_e       state, state_nxt;
    instr_class_e cls;
    alu_op_e      dec_op, alu_op_q;
    logic         accept;
    logic         is_ls_q;
    logic [CNT_W-1:0] cnt;
    logic [10:0]  zimm_q;
    logic [31:0]  avl_q;
    logic         rs1_zero_q;
    logic [15:0]  calc_vtype;
    logic [VL_W-1:0] calc_vl;
    logic         calc_vill;
    logic         retire_nxt, illegal_nxt, timeout_nxt, vlen_nxt;

    assign instr_ready      = (state == IDLE);
    assign accept           = instr_valid & instr_ready;
    assign is_alu_op        = (state == BUSY) & ~is_ls_q;
    assign is_load_store_op = (state == BUSY) & is_ls_q;
    assign ALU_op           = alu_op_q;

    always_comb begin
        cls    = CLS_ILLEGAL;
        dec_op = ALU_ADD;
        case (instr[6:0])
            OPC_OPV: begin
                if (instr[14:12] == F3_OPIVV) begin
                    cls = CLS_ALU;
                    case (instr[31:26])
                        F6_VADD: dec_op = ALU_ADD;
                        F6_VSUB: dec_op = ALU_SUB;
                        F6_VAND: dec_op = ALU_AND;
                        F6_VOR:  dec_op = ALU_OR;
                        F6_VXOR: dec_op = ALU_XOR;
                        default: cls    = CLS_ILLEGAL;
                    endcase
                end else if (instr[14:12] == F3_OPMVV && instr[31:26] == F6_VMUL) begin
                    cls    = CLS_ALU;
                    dec_op = ALU_MUL;
                end else if (instr[14:12] == F3_OPCFG && !instr[31]) begin
                    cls = CLS_CFG;
                end
            end
            OPC_LOAD, OPC_STORE: begin
                if (is_vec_width(instr[14:12])) cls = CLS_LS;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        retire_nxt  = 1'b0;
        illegal_nxt = 1'b0;
        timeout_nxt = 1'b0;
        vlen_nxt    = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    case (cls)
                        CLS_ALU, CLS_LS: begin
                            if (vl_o != '0) state_nxt  = BUSY;
                            else            retire_nxt = 1'b1;
                        end
                        CLS_CFG: state_nxt   = CFG;
                        default: illegal_nxt = 1'b1;
                    endcase
                end
            end
            BUSY: begin
                if (ctrl_done) begin
                    state_nxt  = IDLE;
                    retire_nxt = 1'b1;
                end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                    state_nxt   = IDLE;
                    timeout_nxt = 1'b1;
                end
            end
            CFG: begin
                state_nxt  = IDLE;
                retire_nxt = 1'b1;
                vlen_nxt   = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            instr_retired <= 1'b0;
            illegal_instr <= 1'b0;
            timeout_err   <= 1'b0;
            is_vlen_op    <= 1'b0;
            cnt           <= '0;
        end else begin
            instr_retired <= retire_nxt;
            illegal_instr <= illegal_nxt;
            timeout_err   <= timeout_nxt;
            is_vlen_op    <= vlen_nxt;
            cnt           <= (state == BUSY) ? cnt + 1'b1 : '0;
        end
    end

    // Fields and vsetvli operands are captured on every accepted transfer.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            alu_op_q     <= ALU_ADD;
            is_ls_q      <= 1'b0;
            address_s1   <= '0;
            address_s2   <= '0;
            address_dest <= '0;
            zimm_q       <= '0;
            avl_q        <= '0;
            rs1_zero_q   <= 1'b0;
        end else if (accept) begin
            alu_op_q     <= dec_op;
            is_ls_q      <= (cls == CLS_LS);
            address_s1   <= instr[19:15];
            address_s2   <= instr[24:20];
            address_dest <= instr[11:7];
            zimm_q       <= instr[30:20];
            avl_q        <= avl_i;
            rs1_zero_q   <= (instr[19:15] == 5'd0);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vtype_o <= '0;
            vl_o    <= '0;
        end else if (state == CFG) begin
            vtype_o <= calc_vtype;
            vl_o    <= calc_vill ? '0 : calc_vl;
        end
    end

    vl_calc #(
        .VLEN (VLEN),
        .VL_W (VL_W)
    ) u_vl_calc (
        .zimm     (zimm_q),
        .avl      (avl_q),
        .rs1_zero (rs1_zero_q),
        .vtype    (calc_vtype),
        .vl       (calc_vl),
        .vill     (calc_vill)
    );

endmodule

// File: tb/tb_vector_instr_decoder.sv
// Directed self-checking bench for vector_instr_decoder.
module tb_vector_instr_decoder;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [31:0] instr = '0;
    logic [31:0] avl_i = '0;
    logic        ctrl_done = 1'b0;
    logic [2:0]  ALU_op;
    logic [4:0]  address_s1, address_s2, address_dest;
    logic        is_alu_op, is_load_store_op, is_vlen_op;
    logic [15:0] vtype_o;
    logic [8:0]  vl_o;
    logic        instr_retired, illegal_instr, timeout_err;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    vector_instr_decoder #(
        .VLEN    (256),
        .TIMEOUT (1023),
        .VL_W    (9)
    ) dut (
        .clk              (clk),
        .rstn             (rstn),
        .instr_valid      (instr_valid),
        .instr_ready      (instr_ready),
        .instr            (instr),
        .avl_i            (avl_i),
        .ctrl_done        (ctrl_done),
        .ALU_op           (ALU_op),
        .address_s1       (address_s1),
        .address_s2       (address_s2),
        .address_dest     (address_dest),
        .is_alu_op        (is_alu_op),
        .is_load_store_op (is_load_store_op),
        .is_vlen_op       (is_vlen_op),
        .vtype_o          (vtype_o),
        .vl_o             (vl_o),
        .instr_retired    (instr_retired),
        .illegal_instr    (illegal_instr),
        .timeout_err      (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] w, input logic [31:0] a);
        instr_valid = 1'b1;
        instr       = w;
        avl_i       = a;
        cycle();
        instr_valid = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        #12;
        vectors++;
        if ({instr_ready, is_alu_op, is_load_store_op, is_vlen_op, instr_retired, illegal_instr, timeout_err} !== 7'b1000000) begin
            miscompares++;
            $display("FAIL reset_strobes got=%b want=1000000", {instr_ready, is_alu_op, is_load_store_op, is_vlen_op, instr_retired, illegal_instr, timeout_err});
        end
        vectors++;
        if (vtype_o !== 16'h0000 || vl_o !== 9'd0) begin
            miscompares++;
            $display("FAIL reset_cfg got vtype=%h vl=%0d want 0000/0", vtype_o, vl_o);
        end
        @(negedge clk);
        rstn = 1'b1;
        cycle();
    endtask

    task automatic test_noop_vl0();
        issue(32'h022081D7, 32'd0);
        vectors++;
        if (is_alu_op !== 1'b0 || instr_retired !== 1'b1 || instr_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL noop_vl0 got alu=%b ret=%b rdy=%b want 0 1 1", is_alu_op, instr_retired, instr_ready);
        end
        cycle();
        vectors++;
        if (instr_retired !== 1'b0 || is_alu_op !== 1'b0) begin
            miscompares++;
            $display("FAIL noop_vl0_after got ret=%b alu=%b want 0 0", instr_retired, is_alu_op);
        end
    endtask

    task automatic test_vsetvli();
        logic [31:0] avls [3] = '{32'd100, 32'd5, 32'h00010005};
        logic [8:0]  vls  [3] = '{9'd8, 9'd5, 9'd8};
        for (int i = 0; i < 3; i++) begin
            issue(32'h010170D7, avls[i]);
            vectors++;
            if (instr_ready !== 1'b0 || is_vlen_op !== 1'b0) begin
                miscompares++;
                $display("FAIL vsetvli_cfg[%0d] got rdy=%b vlen=%b want 0 0", i, instr_ready, is_vlen_op);
            end
            cycle();
            vectors++;
            if (vtype_o !== 16'h0010 || vl_o !== vls[i] || is_vlen_op !== 1'b1 || instr_retired !== 1'b1) begin
                miscompares++;
                $display("FAIL vsetvli[%0d] got vtype=%h vl=%0d vlen=%b ret=%b want 0010 %0d 1 1", i, vtype_o, vl_o, is_vlen_op, instr_retired, vls[i]);
            end
            cycle();
            vectors++;
            if (is_vlen_op !== 1'b0 || instr_retired !== 1'b0 || instr_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL vsetvli_pulse[%0d] got vlen=%b ret=%b rdy=%b want 0 0 1", i, is_vlen_op, instr_retired, instr_ready);
            end
        end
    endtask

    task automatic test_alu();
        logic [31:0] words [4] = '{32'h022081D7, 32'h0A2081D7, 32'h9620A1D7, 32'h2E2081D7};
        logic [2:0]  ops   [4] = '{3'd0, 3'd1, 3'd5, 3'd4};
        for (int i = 0; i < 4; i++) begin
            issue(words[i], 32'd0);
            for (int c = 0; c < 3; c++) begin
                vectors++;
                if (is_alu_op !== 1'b1 || is_load_store_op !== 1'b0 || ALU_op !== ops[i] || address_s1 !== 5'd1
                    || address_s2 !== 5'd2 || address_dest !== 5'd3 || instr_retired !== 1'b0 || instr_ready !== 1'b0) begin
                    miscompares++;
                    $display("FAIL alu_hold[%0d.%0d] got alu=%b ls=%b op=%0d s1=%0d s2=%0d d=%0d ret=%b rdy=%b want 1 0 %0d 1 2 3 0 0",
                             i, c, is_alu_op, is_load_store_op, ALU_op, address_s1, address_s2, address_dest, instr_retired, instr_ready, ops[i]);
                end
                cycle();
            end
            ctrl_done = 1'b1;
            cycle();
            ctrl_done = 1'b0;
            vectors++;
            if (is_alu_op !== 1'b0 || instr_retired !== 1'b1 || instr_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL alu_done[%0d] got alu=%b ret=%b rdy=%b want 0 1 1", i, is_alu_op, instr_retired, instr_ready);
            end
            cycle();
        end
    endtask

    task automatic test_load_store();
        issue(32'h0202E207, 32'd0);
        vectors++;
        if (is_load_store_op !== 1'b1 || is_alu_op !== 1'b0 || address_dest !== 5'd4 || address_s1 !== 5'd5 || address_s2 !== 5'd0) begin
            miscompares++;
            $display("FAIL load got ls=%b alu=%b d=%0d s1=%0d s2=%0d want 1 0 4 5 0", is_load_store_op, is_alu_op, address_dest, address_s1, address_s2);
        end
        ctrl_done = 1'b1;
        cycle();
        ctrl_done = 1'b0;
        vectors++;
        if (is_load_store_op !== 1'b0 || instr_retired !== 1'b1) begin
            miscompares++;
            $display("FAIL load_done got ls=%b ret=%b want 0 1", is_load_store_op, instr_retired);
        end
        cycle();
        // store, vse8 v6,(x7)
        issue(32'h02038327, 32'd0);
        vectors++;
        if (is_load_store_op !== 1'b1 || address_dest !== 5'd6 || address_s1 !== 5'd7) begin
            miscompares++;
            $display("FAIL store got ls=%b d=%0d s1=%0d want 1 6 7", is_load_store_op, address_dest, address_s1);
        end
        ctrl_done = 1'b1;
        cycle();
        ctrl_done = 1'b0;
        cycle();
    endtask

    task automatic test_illegal();
        logic [31:0] words [4] = '{32'h00000013, 32'h02029207, 32'h062081D7, 32'h810170D7};
        for (int i = 0; i < 4; i++) begin
            issue(words[i], 32'd0);
            vectors++;
            if (illegal_instr !== 1'b1 || instr_ready !== 1'b1 || instr_retired !== 1'b0 || is_alu_op !== 1'b0 || is_load_store_op !== 1'b0) begin
                miscompares++;
                $display("FAIL illegal[%0d] got ill=%b rdy=%b ret=%b alu=%b ls=%b want 1 1 0 0 0", i, illegal_instr, instr_ready, instr_retired, is_alu_op, is_load_store_op);
            end
            cycle();
            vectors++;
            if (illegal_instr !== 1'b0) begin
                miscompares++;
                $display("FAIL illegal_pulse[%0d] got=%b want 0", i, illegal_instr);
            end
        end
    endtask

    task automatic test_done_ignored();
        ctrl_done = 1'b1;
        cycle();
        ctrl_done = 1'b0;
        vectors++;
        if (instr_retired !== 1'b0 || instr_ready !== 1'b1 || timeout_err !== 1'b0) begin
            miscompares++;
            $display("FAIL done_idle got ret=%b rdy=%b to=%b want 0 1 0", instr_retired, instr_ready, timeout_err);
        end
    endtask

    task automatic test_cfg_edges();
        logic [31:0] words [3] = '{32'h003070D7, 32'h000070D7, 32'h015170D7};
        logic [15:0] vts   [3] = '{16'h0003, 16'h0000, 16'h8000};
        logic [8:0]  vls   [3] = '{9'd256, 9'd32, 9'd0};
        for (int i = 0; i < 3; i++) begin
            issue(words[i], 32'd3);
            cycle();
            vectors++;
            if (vtype_o !== vts[i] || vl_o !== vls[i] || is_vlen_op !== 1'b1) begin
                miscompares++;
                $display("FAIL cfg_edge[%0d] got vtype=%h vl=%0d vlen=%b want %h %0d 1", i, vtype_o, vl_o, is_vlen_op, vts[i], vls[i]);
            end
            cycle();
        end
    endtask

    task automatic test_back_to_back();
        instr_valid = 1'b1;
        instr       = 32'h010170D7;
        avl_i       = 32'd5;
        cycle();
        avl_i = 32'd7;
        cycle();
        vectors++;
        if (vl_o !== 9'd5 || instr_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_first got vl=%0d rdy=%b want 5 1", vl_o, instr_ready);
        end
        cycle();
        instr_valid = 1'b0;
        vectors++;
        if (instr_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_accept got rdy=%b want 0", instr_ready);
        end
        cycle();
        vectors++;
        if (vl_o !== 9'd7 || is_vlen_op !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_second got vl=%0d vlen=%b want 7 1", vl_o, is_vlen_op);
        end
        cycle();
    endtask

    task automatic test_timeout();
        int unsigned cycles = 0;
        int unsigned drops = 0;
        issue(32'h022081D7, 32'd0);
        while (timeout_err !== 1'b1 && cycles < 1100) begin
            if (is_alu_op !== 1'b1) drops++;
            cycle();
            cycles++;
        end
        vectors++;
        if (cycles != 1023 || drops != 0) begin
            miscompares++;
            $display("FAIL timeout_cycles got=%0d early_drops=%0d want 1023 0", cycles, drops);
        end
        vectors++;
        if (is_alu_op !== 1'b0 || instr_ready !== 1'b1 || instr_retired !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout_exit got alu=%b rdy=%b ret=%b want 0 1 0", is_alu_op, instr_ready, instr_retired);
        end
        cycle();
        vectors++;
        if (timeout_err !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout_pulse got=%b want 0", timeout_err);
        end
    endtask

    task automatic test_reset_mid_busy();
        issue(32'h022081D7, 32'd0);
        cycle();
        vectors++;
        if (is_alu_op !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_pre got alu=%b want 1", is_alu_op);
        end
        #2;
        rstn = 1'b0;
        #1;
        vectors++;
        if (is_alu_op !== 1'b0 || vtype_o !== 16'h0000 || vl_o !== 9'd0 || instr_retired !== 1'b0 || instr_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_mid got alu=%b vtype=%h vl=%0d ret=%b rdy=%b want 0 0000 0 0 1", is_alu_op, vtype_o, vl_o, instr_retired, instr_ready);
        end
        @(negedge clk);
        rstn = 1'b1;
        cycle();
        vectors++;
        if (instr_retired !== 1'b0 || is_alu_op !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_after got ret=%b alu=%b want 0 0", instr_retired, is_alu_op);
        end
    endtask

    initial begin
        test_reset();
        test_noop_vl0();
        test_vsetvli();
        test_alu();
        test_load_store();
        test_illegal();
        test_done_ignored();
        test_cfg_edges();
        test_back_to_back();
        test_timeout();
        test_reset_mid_busy();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
